// File: rtl/mem_ctrl.sv
// Byte-serial memory controller: arbitrates instruction fetch and LSB accesses onto
// the byte-wide RAM/IO port, assembling multi-byte reads little-endian.
module mem_ctrl #(
    parameter int IO_BIT = 17
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        clear,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr,
    input  logic        io_buffer_full,
    input  logic        if_valid,
    input  logic [31:0] if_addr,
    output logic        if_done,
    output logic [31:0] if_data,
    input  logic        lsb_valid,
    input  logic        lsb_wr,
    input  logic [1:0]  lsb_size,
    input  logic [31:0] lsb_addr,
    input  logic [31:0] lsb_wdata,
    output logic        lsb_done,
    output logic [31:0] lsb_rdata
);

    typedef enum logic [1:0] {StIdle, StRead, StWrite, StDone} state_e;

    state_e      r_state;
    logic [31:0] r_addr;
    logic [31:0] r_buf;
    logic [31:0] r_wdata;
    logic [31:0] r_mem_a;
    logic [31:0] r_if_data;
    logic [31:0] r_lsb_rdata;
    logic [7:0]  r_mem_dout;
    logic [2:0]  r_n;
    logic [2:0]  r_idx;
    logic        r_is_if;
    logic        r_is_wr;
    logic        r_mem_wr;
    logic        r_if_done;
    logic        r_lsb_done;

    logic        w_io;
    logic        w_wr_fire;
    logic [2:0]  w_idx_inc;
    logic [2:0]  w_lsb_n;
    logic [31:0] w_a_next;
    logic [31:0] w_buf_next;

    assign w_io      = (r_mem_a[IO_BIT -: 2] == 2'b11);
    // A write byte is only issued when not frozen and not blocked by a full UART buffer.
    assign w_wr_fire = r_mem_wr & rdy_in & ~(w_io & io_buffer_full);
    assign w_idx_inc = r_idx + 3'd1;
    assign w_a_next  = r_addr + {29'd0, w_idx_inc};
    assign w_lsb_n   = (lsb_size == 2'b00) ? 3'd1 : (lsb_size == 2'b01) ? 3'd2 : 3'd4;

    // The byte arriving now belongs to the address presented in the previous cycle.
    always_comb begin
        w_buf_next = r_buf;
        case (r_idx)
            3'd1:    w_buf_next[7:0]   = mem_din;
            3'd2:    w_buf_next[15:8]  = mem_din;
            3'd3:    w_buf_next[23:16] = mem_din;
            3'd4:    w_buf_next[31:24] = mem_din;
            default: ;
        endcase
    end

    assign mem_wr    = w_wr_fire;
    assign mem_a     = r_mem_a;
    assign mem_dout  = r_mem_dout;
    assign if_done   = r_if_done & ~clear;
    assign lsb_done  = r_lsb_done & ~(clear & ~r_is_wr);
    assign if_data   = r_if_data;
    assign lsb_rdata = r_lsb_rdata;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state     <= StIdle;
            r_addr      <= '0;
            r_buf       <= '0;
            r_wdata     <= '0;
            r_mem_a     <= '0;
            r_if_data   <= '0;
            r_lsb_rdata <= '0;
            r_mem_dout  <= '0;
            r_n         <= '0;
            r_idx       <= '0;
            r_is_if     <= 1'b0;
            r_is_wr     <= 1'b0;
            r_mem_wr    <= 1'b0;
            r_if_done   <= 1'b0;
            r_lsb_done  <= 1'b0;
        end else if (!rdy_in) begin
            // Bytes seen while frozen are untrustworthy, so a read starts over.
            if (r_state == StRead) begin
                r_idx   <= '0;
                r_mem_a <= r_addr;
            end
        end else begin
            case (r_state)
                StIdle: begin
                    if (lsb_valid && (lsb_wr || !clear)) begin
                        r_addr  <= lsb_addr;
                        r_n     <= w_lsb_n;
                        r_idx   <= '0;
                        r_buf   <= '0;
                        r_is_if <= 1'b0;
                        r_is_wr <= lsb_wr;
                        r_mem_a <= lsb_addr;
                        if (lsb_wr) begin
                            r_state    <= StWrite;
                            r_mem_wr   <= 1'b1;
                            r_mem_dout <= lsb_wdata[7:0];
                            r_wdata    <= {8'd0, lsb_wdata[31:8]};
                        end else begin
                            r_state <= StRead;
                        end
                    end else if (if_valid && !clear && !lsb_valid) begin
                        r_state <= StRead;
                        r_addr  <= if_addr;
                        r_n     <= 3'd4;
                        r_idx   <= '0;
                        r_buf   <= '0;
                        r_is_if <= 1'b1;
                        r_is_wr <= 1'b0;
                        r_mem_a <= if_addr;
                    end
                end
                StRead: begin
                    if (clear) begin
                        r_state <= StIdle;
                        r_mem_a <= '0;
                        r_idx   <= '0;
                    end else begin
                        r_buf <= w_buf_next;
                        if (r_idx == r_n) begin
                            r_state <= StDone;
                            r_mem_a <= '0;
                            if (r_is_if) begin
                                r_if_done <= 1'b1;
                                r_if_data <= w_buf_next;
                            end else begin
                                r_lsb_done  <= 1'b1;
                                r_lsb_rdata <= w_buf_next;
                            end
                        end else begin
                            r_idx   <= w_idx_inc;
                            r_mem_a <= (w_idx_inc < r_n) ? w_a_next : '0;
                        end
                    end
                end
                StWrite: begin
                    if (w_wr_fire) begin
                        if (w_idx_inc == r_n) begin
                            r_state    <= StDone;
                            r_mem_wr   <= 1'b0;
                            r_mem_a    <= '0;
                            r_mem_dout <= '0;
                            r_lsb_done <= 1'b1;
                        end else begin
                            r_idx      <= w_idx_inc;
                            r_mem_a    <= w_a_next;
                            r_mem_dout <= r_wdata[7:0];
                            r_wdata    <= {8'd0, r_wdata[31:8]};
                        end
                    end
                end
                StDone: begin
                    r_state    <= StIdle;
                    r_if_done  <= 1'b0;
                    r_lsb_done <= 1'b0;
                end
                default: r_state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl: byte RAM device model, reference memory, directed and random accesses.
module tb_mem_ctrl;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b1;
    logic        rdy_in = 1'b1;
    logic        clear = 1'b0;
    logic [7:0]  mem_din = 8'd0;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        io_buffer_full = 1'b0;
    logic        if_valid = 1'b0;
    logic [31:0] if_addr = 32'd0;
    logic        if_done;
    logic [31:0] if_data;
    logic        lsb_valid = 1'b0;
    logic        lsb_wr = 1'b0;
    logic [1:0]  lsb_size = 2'd0;
    logic [31:0] lsb_addr = 32'd0;
    logic [31:0] lsb_wdata = 32'd0;
    logic        lsb_done;
    logic [31:0] lsb_rdata;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct packed {
        logic [31:0] c;
        logic [31:0] a;
        logic [7:0]  d;
    } wlog_t;

    wlog_t      wlog[$];
    logic [7:0] dev_mem[4096];
    logic [7:0] ref_mem[4096];

    mem_ctrl #(.IO_BIT(17)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear(clear),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
        .io_buffer_full(io_buffer_full),
        .if_valid(if_valid), .if_addr(if_addr), .if_done(if_done), .if_data(if_data),
        .lsb_valid(lsb_valid), .lsb_wr(lsb_wr), .lsb_size(lsb_size), .lsb_addr(lsb_addr),
        .lsb_wdata(lsb_wdata), .lsb_done(lsb_done), .lsb_rdata(lsb_rdata)
    );

    always #5 clk_in = ~clk_in;

    // Small aliased memory image: keeps the IO-region bits so 0x30000 is distinct from 0x0.
    function automatic int mi(input logic [31:0] a);
        return int'({a[17:16], a[9:0]});
    endfunction

    function automatic logic [7:0] preload_byte(input int i);
        case (i)
            32'h100: return 8'h13;
            32'h101: return 8'h05;
            32'h102: return 8'h10;
            32'h103: return 8'h00;
            32'h020: return 8'hF0;
            default: return 8'(i * 7 + 3);
        endcase
    endfunction

    // RAM device: one-cycle read latency, garbage while frozen, writes on mem_wr.
    always @(posedge clk_in) begin
        cyc <= cyc + 1;
        if (cyc == 0) begin
            for (int i = 0; i < 4096; i++) dev_mem[i] <= preload_byte(i);
        end
        mem_din <= rdy_in ? dev_mem[mi(mem_a)] : 8'($urandom);
        if (mem_wr) begin
            dev_mem[mi(mem_a)] <= mem_dout;
            wlog.push_back({cyc, mem_a, mem_dout});
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_read(input logic [31:0] addr, input int n);
        logic [31:0] r = '0;
        for (int k = 0; k < n; k++) r[8*k +: 8] = ref_mem[mi(addr + 32'(k))];
        return r;
    endfunction

    task automatic ref_store(input logic [31:0] addr, input logic [31:0] wdata, input int n);
        for (int k = 0; k < n; k++) ref_mem[mi(addr + 32'(k))] = wdata[8*k +: 8];
    endtask

    task automatic chk_wlog(input string tag, input logic [31:0] addr, input logic [31:0] wdata,
                            input int n, input int t0);
        chk({tag, "_nwr"}, 32'(wlog.size()), 32'(n));
        for (int k = 0; k < n; k++) begin
            if (k < wlog.size()) begin
                chk({tag, "_wa"}, wlog[k].a, addr + 32'(k));
                chk({tag, "_wd"}, {24'd0, wlog[k].d}, {24'd0, wdata[8*k +: 8]});
                chk({tag, "_wc"}, wlog[k].c, 32'(t0 + 1 + k));
            end
        end
    endtask

    // Issue one request in an idle cycle and wait (bounded) for its done pulse.
    task automatic run_op(input logic fetch, input logic wr, input logic [1:0] size,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          output int lat, output logic [31:0] rdata, output int t0);
        wlog.delete();
        if (fetch) begin
            if_addr  = addr;
            if_valid = 1'b1;
        end else begin
            lsb_wr    = wr;
            lsb_size  = size;
            lsb_addr  = addr;
            lsb_wdata = wdata;
            lsb_valid = 1'b1;
        end
        t0    = cyc;
        lat   = -1;
        rdata = '0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk_in);
            if (fetch ? if_done : lsb_done) begin
                lat   = k;
                rdata = fetch ? if_data : lsb_rdata;
                break;
            end
        end
        if_valid  = 1'b0;
        lsb_valid = 1'b0;
        @(negedge clk_in);
    endtask

    initial begin
        int          lat, t0, ld, fd, cnt, n;
        logic [31:0] rd, ldat, fdat, addr, wdata;
        logic [1:0]  size;
        int          op;

        for (int i = 0; i < 4096; i++) ref_mem[i] = preload_byte(i);
        repeat (3) @(negedge clk_in);
        chk("rst_mem_wr", {31'd0, mem_wr}, 32'd0);
        chk("rst_mem_a", mem_a, 32'd0);
        chk("rst_mem_dout", {24'd0, mem_dout}, 32'd0);
        chk("rst_if_done", {31'd0, if_done}, 32'd0);
        chk("rst_lsb_done", {31'd0, lsb_done}, 32'd0);
        chk("rst_if_data", if_data, 32'd0);
        chk("rst_lsb_rdata", lsb_rdata, 32'd0);
        rst_in = 1'b0;
        @(negedge clk_in);

        // Fetch 0x100: addresses in T+1..T+4, one-cycle done in T+6.
        if_addr  = 32'h100;
        if_valid = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk_in);
            chk("fetch_addr", mem_a, 32'h100 + 32'(k - 1));
        end
        @(negedge clk_in);
        chk("fetch_early_done", {31'd0, if_done}, 32'd0);
        @(negedge clk_in);
        chk("fetch_done", {31'd0, if_done}, 32'd1);
        chk("fetch_data", if_data, 32'h00100513);
        if_valid = 1'b0;
        @(negedge clk_in);
        chk("fetch_done_pulse", {31'd0, if_done}, 32'd0);

        // Both valid: LSB wins, fetch follows after the LSB's DONE cycle.
        lsb_wr = 1'b0; lsb_size = 2'b00; lsb_addr = 32'h20; lsb_valid = 1'b1;
        if_addr = 32'h0; if_valid = 1'b1;
        ld = -1; fd = -1; ldat = '0; fdat = '0;
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk_in);
            if (lsb_done && ld < 0) begin ld = k; ldat = lsb_rdata; lsb_valid = 1'b0; end
            if (if_done && fd < 0) begin fd = k; fdat = if_data; if_valid = 1'b0; end
        end
        lsb_valid = 1'b0; if_valid = 1'b0;
        chk("arb_lsb_lat", 32'(ld), 32'd3);
        chk("arb_lsb_data", ldat, 32'h000000F0);
        chk("arb_if_lat", 32'(fd), 32'd10);
        chk("arb_if_data", fdat, ref_read(32'h0, 4));

        // Store half.
        run_op(1'b0, 1'b1, 2'b01, 32'h40, 32'h1234BEEF, lat, rd, t0);
        chk("sh_lat", 32'(lat), 32'd3);
        chk_wlog("sh", 32'h40, 32'h1234BEEF, 2, t0);
        ref_store(32'h40, 32'h1234BEEF, 2);
        chk("sh_wr_after", {31'd0, mem_wr}, 32'd0);

        // IO store stalled by a full UART buffer for three cycles.
        io_buffer_full = 1'b1;
        lsb_wr = 1'b1; lsb_size = 2'b00; lsb_addr = 32'h30000; lsb_wdata = 32'h41;
        lsb_valid = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk_in);
            chk("io_stall_wr", {31'd0, mem_wr}, 32'd0);
        end
        @(posedge clk_in);
        #1 io_buffer_full = 1'b0;
        @(negedge clk_in);
        chk("io_wr", {31'd0, mem_wr}, 32'd1);
        chk("io_addr", mem_a, 32'h30000);
        chk("io_data", {24'd0, mem_dout}, 32'h41);
        @(negedge clk_in);
        chk("io_done", {31'd0, lsb_done}, 32'd1);
        lsb_valid = 1'b0;
        ref_store(32'h30000, 32'h41, 1);
        @(negedge clk_in);
        chk("io_wr_after", {31'd0, mem_wr}, 32'd0);

        // Clear aborts a fetch.
        if_addr = 32'h100; if_valid = 1'b1;
        @(negedge clk_in);
        @(negedge clk_in);
        clear = 1'b1;
        @(negedge clk_in);
        chk("clr_if_done", {31'd0, if_done}, 32'd0);
        chk("clr_idle_addr", mem_a, 32'd0);
        clear = 1'b0; if_valid = 1'b0;
        cnt = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk_in);
            if (if_done) cnt++;
        end
        chk("clr_no_done", 32'(cnt), 32'd0);

        // Clear does not abort a store.
        clear = 1'b1;
        run_op(1'b0, 1'b1, 2'b10, 32'h50, 32'hCAFEF00D, lat, rd, t0);
        clear = 1'b0;
        chk("clr_sw_lat", 32'(lat), 32'd5);
        chk_wlog("clr_sw", 32'h50, 32'hCAFEF00D, 4, t0);
        ref_store(32'h50, 32'hCAFEF00D, 4);

        // Freeze in T+3..T+4 of a word load; result must still be the correct word.
        lsb_wr = 1'b0; lsb_size = 2'b10; lsb_addr = 32'h80; lsb_valid = 1'b1;
        @(negedge clk_in);
        @(negedge clk_in);
        @(posedge clk_in);
        #1 rdy_in = 1'b0;
        @(negedge clk_in);
        chk("frz_wr", {31'd0, mem_wr}, 32'd0);
        @(posedge clk_in);
        @(posedge clk_in);
        #1 rdy_in = 1'b1;
        ld = -1; ldat = '0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk_in);
            if (lsb_done) begin ld = k; ldat = lsb_rdata; break; end
        end
        lsb_valid = 1'b0;
        chk("frz_done_seen", {31'd0, ld >= 0}, 32'd1);
        chk("frz_data", ldat, ref_read(32'h80, 4));
        @(negedge clk_in);

        // Reset in the middle of a fetch.
        if_addr = 32'h200; if_valid = 1'b1;
        @(negedge clk_in);
        @(negedge clk_in);
        rst_in = 1'b1;
        @(negedge clk_in);
        chk("mid_rst_addr", mem_a, 32'd0);
        chk("mid_rst_done", {31'd0, if_done}, 32'd0);
        chk("mid_rst_lsb_rdata", lsb_rdata, 32'd0);
        chk("mid_rst_if_data", if_data, 32'd0);
        if_valid = 1'b0; rst_in = 1'b0;
        @(negedge clk_in);

        // Random accesses against the reference memory.
        for (int i = 0; i < 60; i++) begin
            op    = int'($urandom_range(0, 2));
            size  = 2'($urandom_range(0, 3));
            wdata = $urandom;
            addr  = ($urandom_range(0, 5) == 0) ? 32'hFFFFFFFC + 32'($urandom_range(0, 3))
                                                : 32'h200 + 32'($urandom_range(0, 255));
            n = (op == 0) ? 4 : (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
            run_op(op == 0, op == 2, size, addr, wdata, lat, rd, t0);
            if (op == 2) begin
                chk("rnd_st_lat", 32'(lat), 32'(n + 1));
                chk_wlog("rnd_st", addr, wdata, n, t0);
                ref_store(addr, wdata, n);
            end else begin
                chk(op == 0 ? "rnd_if_lat" : "rnd_ld_lat", 32'(lat), 32'(n + 2));
                chk(op == 0 ? "rnd_if_data" : "rnd_ld_data", rd, ref_read(addr, n));
            end
            repeat ($urandom_range(0, 2)) @(negedge clk_in);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
